// File: rtl/vector_serializer_pkg.sv
// Shared definitions for the vector serializer: FSM encoding and the packed
// element-slice convention used by the adder tree.
package vector_serializer_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    // Element j of a packed vector occupies [j*width +: width].
    function automatic int unsigned elem_lsb(int unsigned j, int unsigned width);
        return j * width;
    endfunction

endpackage

// File: rtl/vector_serializer.sv
// Unpacks a packed NUM*WIDTH signed vector and streams its elements out one per
// cycle with valid/ready handshakes on both sides.
module vector_serializer
    import vector_serializer_pkg::*;
#(
    parameter int unsigned NUM   = 2,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDXW  = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM*WIDTH-1:0] i_vec,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [IDXW-1:0]      o_idx,
    output logic                 o_last
);

    localparam logic [IDXW-1:0] LastIdx = IDXW'(NUM - 1);

    state_e               state_q, state_d;
    logic [IDXW-1:0]      count_q, count_d;
    logic [NUM*WIDTH-1:0] vec_q, vec_d;
    logic                 in_fire, out_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            count_q <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            vec_q   <= vec_d;
        end
    end

    assign o_valid  = (state_q == StSend);
    assign o_idx    = count_q;
    assign o_last   = o_valid && (count_q == LastIdx);
    assign out_fire = o_valid && o_ready;
    // Ready on the final handshake lets a new vector follow with no bubble.
    assign i_ready  = (state_q == StIdle) || (out_fire && o_last);
    assign in_fire  = i_valid && i_ready;

    always_comb begin
        o_data = '0;
        for (int unsigned j = 0; j < NUM; j++) begin
            if (count_q == IDXW'(j)) begin
                o_data = vec_q[elem_lsb(j, WIDTH) +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        vec_d   = vec_q;
        unique case (state_q)
            StIdle: begin
                if (in_fire) begin
                    state_d = StSend;
                    count_d = '0;
                    vec_d   = i_vec;
                end
            end
            StSend: begin
                if (out_fire) begin
                    if (!o_last) begin
                        count_d = count_q + IDXW'(1);
                    end else if (in_fire) begin
                        count_d = '0;
                        vec_d   = i_vec;
                    end else begin
                        state_d = StIdle;
                        count_d = '0;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Directed self-checking bench for vector_serializer across three configurations:
// NUM=4/WIDTH=8, NUM=1/WIDTH=8 and NUM=2/WIDTH=32.
module tb_vector_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // NUM=4, WIDTH=8
    logic [31:0] d4_i_vec = '0;
    logic        d4_i_valid = 1'b0, d4_i_ready, d4_o_valid, d4_o_ready = 1'b0, d4_o_last;
    logic [7:0]  d4_o_data;
    logic [1:0]  d4_o_idx;

    // NUM=1, WIDTH=8
    logic [7:0]  d1_i_vec = '0;
    logic        d1_i_valid = 1'b0, d1_i_ready, d1_o_valid, d1_o_ready = 1'b0, d1_o_last;
    logic [7:0]  d1_o_data;
    logic [0:0]  d1_o_idx;

    // NUM=2, WIDTH=32
    logic [63:0] d2_i_vec = '0;
    logic        d2_i_valid = 1'b0, d2_i_ready, d2_o_valid, d2_o_ready = 1'b0, d2_o_last;
    logic [31:0] d2_o_data;
    logic [0:0]  d2_o_idx;

    vector_serializer #(.NUM(4), .WIDTH(8)) u_d4 (
        .clk(clk), .rst_n(rst_n), .i_vec(d4_i_vec), .i_valid(d4_i_valid),
        .i_ready(d4_i_ready), .o_data(d4_o_data), .o_valid(d4_o_valid),
        .o_ready(d4_o_ready), .o_idx(d4_o_idx), .o_last(d4_o_last)
    );

    vector_serializer #(.NUM(1), .WIDTH(8)) u_d1 (
        .clk(clk), .rst_n(rst_n), .i_vec(d1_i_vec), .i_valid(d1_i_valid),
        .i_ready(d1_i_ready), .o_data(d1_o_data), .o_valid(d1_o_valid),
        .o_ready(d1_o_ready), .o_idx(d1_o_idx), .o_last(d1_o_last)
    );

    vector_serializer #(.NUM(2), .WIDTH(32)) u_d2 (
        .clk(clk), .rst_n(rst_n), .i_vec(d2_i_vec), .i_valid(d2_i_valid),
        .i_ready(d2_i_ready), .o_data(d2_o_data), .o_valid(d2_o_valid),
        .o_ready(d2_o_ready), .o_idx(d2_o_idx), .o_last(d2_o_last)
    );

    localparam logic [31:0] VecA = {8'h04, 8'hFD, 8'h02, 8'h01};
    localparam logic [31:0] VecB = {8'h80, 8'h7F, 8'h10, 8'hF0};
    logic [7:0] exp_a [4] = '{8'h01, 8'h02, 8'hFD, 8'h04};
    logic [7:0] exp_b [4] = '{8'hF0, 8'h10, 8'h7F, 8'h80};

    // Present VecA on d4 at a negedge; accepted at the following posedge.
    task automatic load_a();
        @(negedge clk);
        d4_i_vec   = VecA;
        d4_i_valid = 1'b1;
        #1;
        n_checks++;
        if (d4_i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_i_ready: got %b want 1", d4_i_ready);
        end
        @(posedge clk);
        #1;
        d4_i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({d4_o_valid, d4_o_data, d4_o_idx, d4_o_last, d4_i_ready} !== {1'b0, 8'h00, 2'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_d4: got v=%b d=%h i=%0d l=%b r=%b want v=0 d=00 i=0 l=0 r=1",
                     d4_o_valid, d4_o_data, d4_o_idx, d4_o_last, d4_i_ready);
        end
        n_checks++;
        if ({d1_o_valid, d1_o_data, d1_o_last, d1_i_ready} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_d1: got v=%b d=%h l=%b r=%b want v=0 d=00 l=0 r=1",
                     d1_o_valid, d1_o_data, d1_o_last, d1_i_ready);
        end
        n_checks++;
        if ({d2_o_valid, d2_o_data, d2_i_ready} !== {1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_d2: got v=%b d=%h r=%b want v=0 d=0 r=1",
                     d2_o_valid, d2_o_data, d2_i_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        d4_o_ready = 1'b1;
        load_a();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            d4_i_vec = 32'hFFFF_FFFF; // ignored: not accepted while streaming
            #1;
            n_checks++;
            if (d4_o_valid !== 1'b1 || d4_o_data !== exp_a[k] || d4_o_idx !== k[1:0]) begin
                n_fail++;
                $display("FAIL basic_elem%0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                         k, d4_o_valid, d4_o_data, d4_o_idx, exp_a[k], k);
            end
            n_checks++;
            if (d4_o_last !== (k == 3) || d4_i_ready !== (k == 3)) begin
                n_fail++;
                $display("FAIL basic_last_ready%0d: got l=%b r=%b want l=%b r=%b",
                         k, d4_o_last, d4_i_ready, k == 3, k == 3);
            end
        end
        @(negedge clk);
        n_checks++;
        if (d4_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got o_valid=%b want 0", d4_o_valid);
        end
    endtask

    task automatic test_back_to_back();
        d4_o_ready = 1'b1;
        load_a();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                d4_i_vec   = VecB;
                d4_i_valid = 1'b1;
            end else begin
                d4_i_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (d4_o_valid !== 1'b1 || d4_o_data !== (k < 4 ? exp_a[k % 4] : exp_b[k % 4]) ||
                d4_o_idx !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL b2b_elem%0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d", k,
                         d4_o_valid, d4_o_data, d4_o_idx,
                         (k < 4 ? exp_a[k % 4] : exp_b[k % 4]), k % 4);
            end
            if (k == 3) begin
                n_checks++;
                if (d4_i_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_i_ready: got %b want 1", d4_i_ready);
                end
            end
        end
        @(negedge clk);
        d4_i_valid = 1'b0;
        #1;
        n_checks++;
        if (d4_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got o_valid=%b want 0", d4_o_valid);
        end
    endtask

    task automatic test_backpressure();
        int         got = 0;
        logic [7:0] prev_data = '0;
        logic [1:0] prev_idx = '0;
        logic       stalled = 1'b0;
        d4_o_ready = 1'b0;
        load_a();
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk);
            d4_o_ready = ((c % 3) == 0);
            #1;
            if (stalled) begin
                n_checks++;
                if (d4_o_valid !== 1'b1 || d4_o_data !== prev_data || d4_o_idx !== prev_idx) begin
                    n_fail++;
                    $display("FAIL bp_stable%0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d", c,
                             d4_o_valid, d4_o_data, d4_o_idx, prev_data, prev_idx);
                end
            end
            if (d4_o_ready) begin
                n_checks++;
                if (d4_o_valid !== 1'b1 || d4_o_data !== exp_a[got] || d4_o_idx !== got[1:0]) begin
                    n_fail++;
                    $display("FAIL bp_elem%0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d", got,
                             d4_o_valid, d4_o_data, d4_o_idx, exp_a[got], got);
                end
                got++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                prev_data = exp_a[got];
                prev_idx  = got[1:0];
            end
        end
        n_checks++;
        if (got !== 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d elements want 4", got);
        end
        @(negedge clk);
        d4_o_ready = 1'b1;
        #1;
        n_checks++;
        if (d4_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: got o_valid=%b want 0", d4_o_valid);
        end
    endtask

    task automatic test_reset_mid();
        d4_o_ready = 1'b1;
        load_a();
        @(negedge clk); // element 0 shown, accepted at next posedge
        @(negedge clk); // element 1 shown, accepted at next posedge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (d4_o_valid !== 1'b0 || d4_i_ready !== 1'b1 || d4_o_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_async: got v=%b r=%b i=%0d want v=0 r=1 i=0",
                     d4_o_valid, d4_i_ready, d4_o_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (d4_o_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet%0d: got o_valid=%b want 0", k, d4_o_valid);
            end
        end
    endtask

    task automatic test_num1();
        logic [7:0] vals [3] = '{8'd5, 8'hF9, 8'd9};
        d1_o_ready = 1'b1;
        @(negedge clk);
        d1_i_vec   = vals[0];
        d1_i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k < 2) d1_i_vec = vals[k + 1];
            else d1_i_valid = 1'b0;
            #1;
            n_checks++;
            if (d1_o_valid !== 1'b1 || d1_o_data !== vals[k] || d1_o_idx !== 1'b0 ||
                d1_o_last !== 1'b1 || d1_i_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL num1_elem%0d: got v=%b d=%h i=%0d l=%b r=%b want v=1 d=%h i=0 l=1 r=1",
                         k, d1_o_valid, d1_o_data, d1_o_idx, d1_o_last, d1_i_ready, vals[k]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (d1_o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL num1_idle: got o_valid=%b want 0", d1_o_valid);
        end
    endtask

    task automatic test_sign_width();
        logic [31:0] exp_s [2] = '{32'h7FFF_FFFF, 32'h8000_0000};
        d2_o_ready = 1'b1;
        @(negedge clk);
        d2_i_vec   = {32'h8000_0000, 32'h7FFF_FFFF};
        d2_i_valid = 1'b1;
        @(posedge clk);
        #1;
        d2_i_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (d2_o_valid !== 1'b1 || d2_o_data !== exp_s[k] || d2_o_idx !== k[0:0] ||
                d2_o_last !== (k == 1)) begin
                n_fail++;
                $display("FAIL sign_elem%0d: got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                         k, d2_o_valid, d2_o_data, d2_o_idx, d2_o_last, exp_s[k], k, k == 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_num1();
        test_sign_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_serializer.md
Name: vector_serializer

Overview:
- Parallel-to-serial unpacker for packed signed vectors, the other end of the N-input adder-tree packing convention. The adder tree reduces element j from bits [j*WIDTH +: WIDTH] to one sum; this block takes that same packed NUM*WIDTH bus and streams its elements out one per cycle.
- Used in backprop to hand error/gradient vectors element-by-element to per-neuron units, with valid/ready handshakes on both sides.

Parameters:
NUM, 2, elements per packed vector (>=1)
WIDTH, 32, bits per signed element
IDXW, $clog2(NUM) (min 1), width of element index output

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_vec  in  NUM*WIDTH  packed signed vector, element j at [j*WIDTH +: WIDTH]
i_valid  in  1  i_vec valid
i_ready  out  1  block can accept a vector this cycle
o_data  out  WIDTH  current signed element
o_valid  out  1  o_data valid
o_ready  in  1  downstream accepts o_data
o_idx  out  IDXW  index j of o_data
o_last  out  1  high when o_idx == NUM-1 and o_valid

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: o_valid=0, o_data=0, o_idx=0, o_last=0, i_ready=1, internal vector register=0, state=IDLE.
- States: IDLE (nothing held), SEND (vector held, streaming).
- Input accept: fires when i_valid && i_ready.
  - i_ready = (state==IDLE) || (state==SEND && o_valid && o_ready && o_last).
  - i_ready is combinational from state/count/o_ready. No combinational path from i_valid to i_ready.
- Output accept: fires when o_valid && o_ready.
- IDLE + input accept: latch i_vec, count=0, go to SEND. o_valid rises next cycle, so first-element latency is 1 cycle.
- SEND, output accept, not last: count increments. o_data becomes the next element the following cycle.
- SEND, output accept on last element:
  - If an input accept fires in the same cycle, reload the vector, count=0, stay in SEND. This gives back-to-back vectors with no bubble: NUM cycles per vector at full throughput.
  - Otherwise go to IDLE, o_valid=0.
- Stall: with o_valid=1 and o_ready=0, o_data, o_idx and o_last hold stable. o_valid never drops without a handshake.
- o_data = held element[count], sign preserved bit-exact. No arithmetic.
- o_last = o_valid && (count == NUM-1).
- NUM=1: every element is last. Vectors flow 1 per cycle when o_ready is held high.
- i_vec changes while not accepted are ignored. The held copy is immune to input changes.
- Reset asserted mid-vector: immediate return to reset values. The partial vector is discarded; no residual o_valid after release.
- Count wraps only by reload. It never exceeds NUM-1.

Decomposition:
- Shared package constants: state encoding (IDLE=0, SEND=1) and the element-slice convention (j*WIDTH +: WIDTH), shared with the adder tree.
- No sub-module needed: a single module holding the FSM, counter and vector register. Element select is an indexed part-select on the held register.

Test Plan:
- Basic, NUM=4, WIDTH=8: i_vec={8'h04,8'hFD,8'h02,8'h01}, o_ready=1.
  - Required: o_data 1, 2, -3, 4 on consecutive cycles; o_idx 0..3; o_last only on 4; i_ready=0 during idx 0..2.
- Back-to-back: second vector presented while the last element is accepted.
  - Required: i_ready=1 that cycle; the next cycle shows the new vector's element 0; 8 outputs in 8 cycles, no bubble.
- Backpressure: o_ready toggles 1,0,0,1,...
  - Required: o_data/o_idx stable across stall cycles; all 4 elements delivered in order; none dropped or duplicated.
- Reset mid-stream: rst_n low after element 1 is accepted.
  - Required: o_valid=0 and i_ready=1 asynchronously; after release, no output until a new vector is accepted.
- NUM=1 with o_ready=1 and a continuous i_valid stream 5,-7,9.
  - Required: outputs 5,-7,9 on consecutive cycles, each with o_last=1 and o_idx=0.
- Sign/width, NUM=2, WIDTH=32: i_vec={32'h80000000,32'h7FFFFFFF}.
  - Required: o_data 32'h7FFFFFFF then 32'h80000000, bit-exact.
